// File: rtl/dispense_arbiter.sv
// dispense_arbiter: shares one dispense motor and one coin ejector between two
// vending front panels. Round-robin arbitration, motor on-time sequencing and
// change payout. All outputs are registered.
//
// Optional feature macro: STOCK_TRACK_EN
//   defined   - 4-bit stock counter, sold_out flag and full refund on sold-out
//   undefined - stock is unlimited; sold_out and refund stay 0
module dispense_arbiter #(
    parameter int unsigned PRICE           = 15,
    parameter int unsigned COIN            = 5,
    parameter int unsigned DISPENSE_CYCLES = 4,
    parameter int unsigned STOCK_INIT      = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] change0,
    input  logic [3:0] change1,
    output logic [1:0] grant,
    output logic       motor_on,
    output logic       coin_eject,
    output logic [1:0] done,
    output logic       refund,
    output logic       sold_out
);

    localparam logic [4:0] LP_PRICE      = 5'(PRICE);
    localparam logic [4:0] LP_COIN       = 5'(COIN);
    localparam logic [3:0] LP_DISP_LAST  = 4'(DISPENSE_CYCLES - 1);
    localparam logic [3:0] LP_STOCK_INIT = 4'(STOCK_INIT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GRANT    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // state and datapath registers
    state_t      r_state;
    logic        r_sel;
    logic        r_last;
    logic [3:0]  r_change;
    logic [4:0]  r_coins;
    logic [3:0]  r_cnt;
    logic        r_phase;
    logic        r_refund_flag;
    // output registers
    logic [1:0]  r_grant;
    logic        r_motor;
    logic        r_coin;
    logic [1:0]  r_done;
    logic        r_refund;
    logic        r_sold_out;

    // next-state values
    state_t      w_state_nxt;
    logic        w_sel_nxt;
    logic        w_last_nxt;
    logic [3:0]  w_change_nxt;
    logic [4:0]  w_coins_nxt;
    logic [3:0]  w_cnt_nxt;
    logic        w_phase_nxt;
    logic        w_refund_flag_nxt;
    logic [1:0]  w_grant_nxt;
    logic        w_motor_nxt;
    logic        w_coin_nxt;
    logic [1:0]  w_done_nxt;
    logic        w_refund_nxt;
    logic        w_sold_upd;

    logic        w_pick;
    logic [4:0]  w_sum;
    logic [4:0]  w_n_sale;
    logic [4:0]  w_n_refund;
    logic        w_stock_empty;

`ifdef STOCK_TRACK_EN
    logic [3:0]  r_stock;
    logic        w_stock_dec;

    assign w_stock_empty = (r_stock == 4'd0);
`else
    // without tracking the stock level is the constant load value, never empty
    assign w_stock_empty = (LP_STOCK_INIT == 4'd0);
`endif

    // both requesting: serve the panel that was not served last
    assign w_pick     = (req == 2'b10) ? 1'b1 :
                        (req == 2'b11) ? ~r_last : 1'b0;
    // coin counts: change only, or price plus change when refunding (5 bits wide)
    assign w_sum      = LP_PRICE + {1'b0, r_change};
    assign w_n_sale   = {1'b0, r_change} / LP_COIN;
    assign w_n_refund = w_sum / LP_COIN;

    // next-state and next-output decode, registered below
    always_comb begin
        w_state_nxt       = r_state;
        w_sel_nxt         = r_sel;
        w_last_nxt        = r_last;
        w_change_nxt      = r_change;
        w_coins_nxt       = r_coins;
        w_cnt_nxt         = r_cnt;
        w_phase_nxt       = r_phase;
        w_refund_flag_nxt = r_refund_flag;
        w_grant_nxt       = r_grant;
        w_motor_nxt       = 1'b0;
        w_coin_nxt        = 1'b0;
        w_done_nxt        = 2'b00;
        w_refund_nxt      = 1'b0;
        w_sold_upd        = 1'b0;
`ifdef STOCK_TRACK_EN
        w_stock_dec       = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = 2'b00;
                if (req != 2'b00) begin
                    w_sel_nxt         = w_pick;
                    w_change_nxt      = w_pick ? change1 : change0;
                    w_grant_nxt       = w_pick ? 2'b10 : 2'b01;
                    w_refund_flag_nxt = 1'b0;
                    w_state_nxt       = ST_GRANT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                w_last_nxt = r_sel;
                if (w_stock_empty) begin
                    // sold out: skip the motor and pay back price plus change
                    w_coins_nxt       = w_n_refund;
                    w_refund_flag_nxt = 1'b1;
                    w_phase_nxt       = 1'b0;
                    w_coin_nxt        = 1'b1;
                    w_state_nxt       = ST_CHANGE;
                end else begin
                    w_coins_nxt       = w_n_sale;
                    w_refund_flag_nxt = 1'b0;
                    w_cnt_nxt         = LP_DISP_LAST;
                    w_motor_nxt       = 1'b1;
`ifdef STOCK_TRACK_EN
                    w_stock_dec       = 1'b1;
`endif
                    w_state_nxt       = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_motor_nxt = 1'b1;
                end else if (r_coins != 5'd0) begin
                    w_phase_nxt = 1'b0;
                    w_coin_nxt  = 1'b1;
                    w_state_nxt = ST_CHANGE;
                end else begin
                    w_done_nxt   = r_grant;
                    w_refund_nxt = r_refund_flag;
                    w_sold_upd   = 1'b1;
                    w_state_nxt  = ST_DONE;
                end
            end
            ST_CHANGE: begin
                // phase 0 is the eject-high cycle, phase 1 the gap after it
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    w_coins_nxt = r_coins - 5'd1;
                    if (r_coins == 5'd1) begin
                        w_done_nxt   = r_grant;
                        w_refund_nxt = r_refund_flag;
                        w_sold_upd   = 1'b1;
                        w_state_nxt  = ST_DONE;
                    end else begin
                        w_phase_nxt = 1'b0;
                        w_coin_nxt  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // state, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= 1'b0;
            r_last        <= 1'b1;
            r_change      <= 4'd0;
            r_coins       <= 5'd0;
            r_cnt         <= 4'd0;
            r_phase       <= 1'b0;
            r_refund_flag <= 1'b0;
            r_grant       <= 2'b00;
            r_motor       <= 1'b0;
            r_coin        <= 1'b0;
            r_done        <= 2'b00;
            r_refund      <= 1'b0;
            r_sold_out    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_sel         <= w_sel_nxt;
            r_last        <= w_last_nxt;
            r_change      <= w_change_nxt;
            r_coins       <= w_coins_nxt;
            r_cnt         <= w_cnt_nxt;
            r_phase       <= w_phase_nxt;
            r_refund_flag <= w_refund_flag_nxt;
            r_grant       <= w_grant_nxt;
            r_motor       <= w_motor_nxt;
            r_coin        <= w_coin_nxt;
            r_done        <= w_done_nxt;
            r_refund      <= w_refund_nxt;
            if (w_sold_upd) begin
                r_sold_out <= w_stock_empty;
            end else begin
                r_sold_out <= r_sold_out;
            end
        end
    end

`ifdef STOCK_TRACK_EN
    // stock counter: reloads on reset, decrements on dispense, never wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stock <= LP_STOCK_INIT;
        end else if (w_stock_dec && (r_stock != 4'd0)) begin
            r_stock <= r_stock - 4'd1;
        end else begin
            r_stock <= r_stock;
        end
    end
`endif

    assign grant      = r_grant;
    assign motor_on   = r_motor;
    assign coin_eject = r_coin;
    assign done       = r_done;
    assign refund     = r_refund;
    assign sold_out   = r_sold_out;

endmodule

// File: tb/tb_dispense_arbiter.sv
// Directed bench for dispense_arbiter. Expected traces are built from the
// sale timing: grant cycles 1..T, motor 2..1+D, coins every other cycle,
// done at T = 2 + motor + 2n.
module tb_dispense_arbiter;

    localparam int D = 4;
`ifdef STOCK_TRACK_EN
    localparam int TB_STOCK = 1;
`else
    localparam int TB_STOCK = 15;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] change0;
    logic [3:0] change1;
    logic [1:0] grant;
    logic       motor_on;
    logic       coin_eject;
    logic [1:0] done;
    logic       refund;
    logic       sold_out;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] tr [0:40];

    dispense_arbiter #(
        .PRICE(15), .COIN(5), .DISPENSE_CYCLES(D), .STOCK_INIT(TB_STOCK)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .change0(change0), .change1(change1),
        .grant(grant), .motor_on(motor_on), .coin_eject(coin_eject),
        .done(done), .refund(refund), .sold_out(sold_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // record {grant, motor, coin, done, refund, sold_out} for cycles 1..ncyc
    task automatic capture(input int ncyc);
        @(negedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            tr[c] = {grant, motor_on, coin_eject, done, refund, sold_out};
        end
    endtask

    // run one sale whose request was just raised (posedge+1, DUT idle)
    task automatic sale(input string tag, input logic [1:0] g, input int n,
                        input bit disp, input bit rf, input bit sob, input bit soa);
        int mot;
        int t;
        int cs;
        logic [7:0] e;
        mot = disp ? D : 0;
        t   = 2 + mot + 2 * n;
        cs  = 2 + mot;
        capture(t);
        for (int c = 1; c <= t; c++) begin
            e[7:6] = g;
            e[5]   = disp && (c >= 2) && (c <= 1 + D);
            e[4]   = (c >= cs) && (c < cs + 2 * n) && (((c - cs) % 2) == 0);
            e[3:2] = (c == t) ? g : 2'b00;
            e[1]   = rf && (c == t);
            e[0]   = (c == t) ? soa : sob;
            chk($sformatf("%s_c%0d", tag, c), {24'd0, tr[c]}, {24'd0, e});
        end
        @(posedge clk);
        #1;
        req = req & ~g;
        chk($sformatf("%s_idle", tag), {26'd0, grant, done, motor_on, coin_eject}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {24'd0, grant, motor_on, coin_eject, done, refund, sold_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        req     = 2'b00;
        change0 = 4'd0;
        change1 = 4'd0;
        do_reset();

`ifdef STOCK_TRACK_EN
        // stock of one: first sale dispenses and flags sold_out at done
        change0 = 4'd0;
        req = 2'b01;
        sale("stock_first", 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b1);
        // second sale refunds price: (15+0)/5 = 3 coins, no motor
        req = 2'b01;
        sale("stock_refund", 2'b01, 3, 1'b0, 1'b1, 1'b1, 1'b1);
        do_reset();
        chk("stock_reload_soldout", {31'd0, sold_out}, 32'd0);
        change0 = 4'd7;
        req = 2'b01;
        sale("stock_rem7", 2'b01, 1, 1'b1, 1'b0, 1'b0, 1'b1);
`else
        // panel 0, no change
        change0 = 4'd0;
        req = 2'b01;
        sale("p0_chg0", 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0);

        // panel 1, change 5 -> one coin
        change1 = 4'd5;
        req = 2'b10;
        sale("p1_chg5", 2'b10, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // both requesting: panel 0 then panel 1 (last was 1)
        req = 2'b11;
        sale("rr_a_p0", 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        sale("rr_a_p1", 2'b10, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        req = 2'b11;
        sale("rr_b_p0", 2'b01, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        sale("rr_b_p1", 2'b10, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset during dispense
        change0 = 4'd0;
        req = 2'b01;
        repeat (3) @(negedge clk);
        chk("mid_motor_before_rst", {31'd0, motor_on}, 32'd1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        req = 2'b00;
        #1;
        chk("mid_rst_motor", {31'd0, motor_on}, 32'd0);
        chk("mid_rst_grant", {30'd0, grant}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        change1 = 4'd5;
        req = 2'b10;
        sale("post_rst_p1", 2'b10, 1, 1'b1, 1'b0, 1'b0, 1'b0);

        // change 7 -> one coin, remainder dropped
        change0 = 4'd7;
        req = 2'b01;
        sale("rem7", 2'b01, 1, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
